capture_seq: RTL and testbench
==============================

// Module: capture_seq
// PURPOSE
//  Run-control sequencer for the capture datapath. Latches the host run config and derives the capture counter limits.
//  Optionally runs a DSO zero calibration first. Gates sample_en and waits for capture_done, then for the SDRAM writer to drain.
//  Sits between the host config registers and the capture block, in the core_clk domain.
// PARAMETERS
//  SETTLE_CYC    4        core_clk cycles sample_en is held low between CALC and ARM (clean rising edge for capture)
//  ZERO_TMO      1048576  max cycles waiting for dso_setZero_done before abort (0 = no timeout)
//  MIN_DEPTH     16       smallest accepted cfg_depth; smaller values raise cfg_err
// PORTS
//  core_clk            in   1   core clock; all logic on posedge
//  core_rst            in   1   synchronous, active-high reset
//  run_start           in   1   1-cycle pulse: begin a run with current cfg_*
//  run_stop            in   1   1-cycle pulse: abort current run
//  cfg_depth           in   32  total samples per run
//  cfg_trig_pos        in   32  pre-trigger samples
//  cfg_trig_en         in   1   trigger enabled for this run
//  cfg_full_speed      in   1   full-speed sampling (capture uses trig_set_pos_minus1)
//  cfg_zero_req        in   1   run DSO zero calibration before arming
//  capture_done        in   1   1-cycle pulse from capture
//  dso_setZero_done    in   1   1-cycle pulse from capture
//  wr_idle             in   1   SDRAM writer FIFO empty and no burst in flight
//  sample_en           out  1   capture enable
//  trig_en             out  1   registered copy of cfg_trig_en, held for the run
//  full_speed          out  1   registered copy of cfg_full_speed
//  sample_depth        out  32  latched depth
//  sample_last_cnt     out  32  depth-1
//  trig_set_pos        out  32  clamped trigger position
//  trig_set_pos_minus1 out  32  trig_set_pos-1, saturating at 0
//  after_trig_depth    out  32  sample_last_cnt - trig_set_pos
//  sample_real_start   out  32  (pos==0) ? 0 : depth-pos
//  dso_setZero         out  1   1-cycle calibration request pulse
//  busy                out  1   state != IDLE
//  run_end             out  1   1-cycle pulse when run finishes (normal, abort, or error)
//  run_status          out  2   00 ok, 01 aborted, 10 cfg_err, 11 zero timeout; valid from run_end
// BEHAVIOUR
//  Reset values
//   - All outputs 0, state IDLE, run_status 00.
//   - Reset mid-run drops sample_en on the next edge; no run_end is produced.
//  FSM
//   - IDLE -> CALC on run_start.
//   - CALC (1 cycle): latch cfg_* and compute derived values.
//       - cfg_depth < MIN_DEPTH: status=10, go DONE.
//       - Otherwise go SETTLE.
//   - SETTLE: count SETTLE_CYC cycles with sample_en=0.
//       - Then ZERO if cfg_zero_req, else ARM.
//   - ZERO: pulse dso_setZero on entry. sample_en=1 so calibration samples flow.
//       - On dso_setZero_done: sample_en=0, go SETTLE (zero_req consumed).
//       - Timeout: status=11, go FLUSH.
//   - ARM: sample_en=1.
//       - On capture_done: go FLUSH.
//       - On run_stop: status=01, go FLUSH.
//   - FLUSH: sample_en=0; wait for wr_idle, then go DONE.
//   - DONE: run_end=1 for one cycle, go IDLE.
//  Arithmetic
//   - trig_set_pos = min(cfg_trig_pos, depth-1).
//   - All derived values are registered in CALC and stay stable until the next CALC.
//   - All arithmetic is 32-bit unsigned; the only subtraction that can underflow is guarded.
//  Simultaneous events and boundaries
//   - run_start while busy is ignored.
//   - run_stop in IDLE/CALC/DONE is ignored. In SETTLE or ZERO it goes straight to FLUSH with status=01.
//   - capture_done and run_stop in the same ARM cycle: capture_done wins, status=00.
//   - Timeout and dso_setZero_done in the same cycle: done wins.
//   - Non-trigger run (cfg_trig_en=0): trig_set_pos, trig_set_pos_minus1 and sample_real_start are forced to 0.
//  Latency
//   - sample_en rises exactly 1+SETTLE_CYC cycles after run_start (no zero calibration).
//   - sample_en falls the cycle after capture_done.
// STRUCTURE
//  - Shared package capture_pkg: state encodings, run_status codes, MIN_DEPTH default.
//  - One sub-module, capture_cfg_calc: purely registered derivation of the limits from depth/pos/trig_en, enabled in CALC.
//  - FSM, settle counter and timeout counter stay in capture_seq.
// TESTING
//  1. depth=1024, pos=256, trig_en=1, no zero -> last=1023, pos=256, minus1=255, after=767, real_start=768; sample_en high 5 cycles after start.
//  2. ARM, capture_done pulse, wr_idle low 10 cycles -> sample_en low next cycle; run_end exactly 1 cycle after wr_idle rises; status=00.
//  3. depth=8 -> no sample_en ever; run_end 2 cycles after start; status=10.
//  4. cfg_zero_req=1, ZERO_TMO=64, no done -> dso_setZero one pulse; run_end with status=11; sample_en low at FLUSH.
//  5. run_stop and capture_done in same ARM cycle -> status=00. Repeat with run_stop alone -> status=01.
//  6. depth=100, pos=500 -> trig_set_pos=99, after=0; core_rst asserted in ARM -> sample_en=0 next edge, busy=0, no run_end.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encodings, run status codes and defaults for the capture run sequencer.
package capture_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CALC, S_SETTLE, S_ZERO, S_ARM, S_FLUSH, S_DONE} state_t;
   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_ABORT    = 2'b01;
   localparam logic [1:0] ST_CFG_ERR  = 2'b10;
   localparam logic [1:0] ST_ZERO_TMO = 2'b11;
   localparam int unsigned MIN_DEPTH_DEF = 16;
endpackage

// File: rtl/capture_cfg_calc.sv
// capture_cfg_calc: registered derivation of capture counter limits from depth, trigger position and trigger enable.
module capture_cfg_calc (
   input  logic        core_clk,
   input  logic        core_rst,
   input  logic        i_en,
   input  logic [31:0] i_depth,
   input  logic [31:0] i_trig_pos,
   input  logic        i_trig_en,
   output logic        o_trig_en,
   output logic [31:0] o_depth,
   output logic [31:0] o_last_cnt,
   output logic [31:0] o_pos,
   output logic [31:0] o_pos_minus1,
   output logic [31:0] o_after,
   output logic [31:0] o_real_start
);
   logic [31:0] w_last;
   logic [31:0] w_pos;
   // Position is clamped to the last sample so after-trigger depth never underflows.
   assign w_last = (i_depth == 32'd0) ? 32'd0 : i_depth - 32'd1;
   assign w_pos  = !i_trig_en ? 32'd0 : (i_trig_pos > w_last) ? w_last : i_trig_pos;
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         o_trig_en    <= 1'b0;
         o_depth      <= '0;
         o_last_cnt   <= '0;
         o_pos        <= '0;
         o_pos_minus1 <= '0;
         o_after      <= '0;
         o_real_start <= '0;
      end else if (i_en) begin
         o_trig_en    <= i_trig_en;
         o_depth      <= i_depth;
         o_last_cnt   <= w_last;
         o_pos        <= w_pos;
         o_pos_minus1 <= (w_pos == 32'd0) ? 32'd0 : w_pos - 32'd1;
         o_after      <= w_last - w_pos;
         o_real_start <= (w_pos == 32'd0) ? 32'd0 : i_depth - w_pos;
      end
   end
endmodule

// File: rtl/capture_seq.sv
// capture_seq: run-control sequencer; latches run config, optional zero calibration,
// gates sample_en until capture_done, then waits for the SDRAM writer to drain.
module capture_seq
   import capture_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned ZERO_TMO   = 1048576,
   parameter int unsigned MIN_DEPTH  = MIN_DEPTH_DEF
) (
   input  logic        core_clk,
   input  logic        core_rst,
   input  logic        run_start,
   input  logic        run_stop,
   input  logic [31:0] cfg_depth,
   input  logic [31:0] cfg_trig_pos,
   input  logic        cfg_trig_en,
   input  logic        cfg_full_speed,
   input  logic        cfg_zero_req,
   input  logic        capture_done,
   input  logic        dso_setZero_done,
   input  logic        wr_idle,
   output logic        sample_en,
   output logic        trig_en,
   output logic        full_speed,
   output logic [31:0] sample_depth,
   output logic [31:0] sample_last_cnt,
   output logic [31:0] trig_set_pos,
   output logic [31:0] trig_set_pos_minus1,
   output logic [31:0] after_trig_depth,
   output logic [31:0] sample_real_start,
   output logic        dso_setZero,
   output logic        busy,
   output logic        run_end,
   output logic [1:0]  run_status
);
   state_t      r_state, w_next;
   logic [1:0]  r_status, w_status;
   logic [31:0] r_cnt, r_tmo;
   logic        r_zero_pend, r_full_speed, r_setzero;
   logic        w_settled, w_tmo, w_cfg_err;

   // CALC is the first low cycle of the settle window, so the counter starts at 1 from CALC.
   assign w_settled = (r_cnt + 32'd1) >= 32'(SETTLE_CYC);
   assign w_tmo     = (ZERO_TMO != 0) && (r_tmo == 32'(ZERO_TMO) - 32'd1);
   assign w_cfg_err = cfg_depth < 32'(MIN_DEPTH);

   always_comb begin
      w_next   = r_state;
      w_status = r_status;
      case (r_state)
         S_IDLE:   w_next = run_start ? S_CALC : S_IDLE;
         S_CALC: begin
            w_status = w_cfg_err ? ST_CFG_ERR : ST_OK;
            w_next   = w_cfg_err ? S_DONE : S_SETTLE;
         end
         S_SETTLE: begin
            if (run_stop) begin
               w_next   = S_FLUSH;
               w_status = ST_ABORT;
            end else if (w_settled) w_next = r_zero_pend ? S_ZERO : S_ARM;
         end
         S_ZERO: begin
            if (dso_setZero_done) w_next = S_SETTLE;
            else if (run_stop) begin
               w_next   = S_FLUSH;
               w_status = ST_ABORT;
            end else if (w_tmo) begin
               w_next   = S_FLUSH;
               w_status = ST_ZERO_TMO;
            end
         end
         S_ARM: begin
            if (capture_done) w_next = S_FLUSH;
            else if (run_stop) begin
               w_next   = S_FLUSH;
               w_status = ST_ABORT;
            end
         end
         S_FLUSH:  w_next = wr_idle ? S_DONE : S_FLUSH;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_state      <= S_IDLE;
         r_status     <= ST_OK;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_zero_pend  <= 1'b0;
         r_full_speed <= 1'b0;
         r_setzero    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_status  <= w_status;
         r_cnt     <= (r_state == S_SETTLE) ? r_cnt + 32'd1 : (r_state == S_CALC) ? 32'd1 : 32'd0;
         r_tmo     <= (r_state == S_ZERO) ? r_tmo + 32'd1 : 32'd0;
         r_setzero <= (w_next == S_ZERO) && (r_state != S_ZERO);
         if (r_state == S_CALC) begin
            r_zero_pend  <= cfg_zero_req;
            r_full_speed <= cfg_full_speed;
         end else if (r_state == S_ZERO && dso_setZero_done) r_zero_pend <= 1'b0;
      end
   end

   capture_cfg_calc u_calc (
      .core_clk     (core_clk),
      .core_rst     (core_rst),
      .i_en         (r_state == S_CALC),
      .i_depth      (cfg_depth),
      .i_trig_pos   (cfg_trig_pos),
      .i_trig_en    (cfg_trig_en),
      .o_trig_en    (trig_en),
      .o_depth      (sample_depth),
      .o_last_cnt   (sample_last_cnt),
      .o_pos        (trig_set_pos),
      .o_pos_minus1 (trig_set_pos_minus1),
      .o_after      (after_trig_depth),
      .o_real_start (sample_real_start)
   );

   assign sample_en   = (r_state == S_ARM) || (r_state == S_ZERO);
   assign busy        = r_state != S_IDLE;
   assign run_end     = r_state == S_DONE;
   assign run_status  = r_status;
   assign full_speed  = r_full_speed;
   assign dso_setZero = r_setzero;
endmodule

// File: tb/tb_capture_seq.sv
// tb_capture_seq: directed checks of capture_seq run sequencing, derived limits and abort paths.
module tb_capture_seq;
   logic        core_clk = 1'b0, core_rst = 1'b1;
   logic        run_start = 1'b0, run_stop = 1'b0;
   logic [31:0] cfg_depth = '0, cfg_trig_pos = '0;
   logic        cfg_trig_en = 1'b0, cfg_full_speed = 1'b0, cfg_zero_req = 1'b0;
   logic        capture_done = 1'b0, dso_setZero_done = 1'b0, wr_idle = 1'b1;
   logic        sample_en, trig_en, full_speed, dso_setZero, busy, run_end;
   logic [31:0] sample_depth, sample_last_cnt, trig_set_pos, trig_set_pos_minus1;
   logic [31:0] after_trig_depth, sample_real_start;
   logic [1:0]  run_status;
   int          n_chk = 0, n_fail = 0;

   capture_seq #(.SETTLE_CYC(4), .ZERO_TMO(64), .MIN_DEPTH(16)) dut (
      .core_clk(core_clk), .core_rst(core_rst), .run_start(run_start), .run_stop(run_stop),
      .cfg_depth(cfg_depth), .cfg_trig_pos(cfg_trig_pos), .cfg_trig_en(cfg_trig_en),
      .cfg_full_speed(cfg_full_speed), .cfg_zero_req(cfg_zero_req), .capture_done(capture_done),
      .dso_setZero_done(dso_setZero_done), .wr_idle(wr_idle), .sample_en(sample_en),
      .trig_en(trig_en), .full_speed(full_speed), .sample_depth(sample_depth),
      .sample_last_cnt(sample_last_cnt), .trig_set_pos(trig_set_pos),
      .trig_set_pos_minus1(trig_set_pos_minus1), .after_trig_depth(after_trig_depth),
      .sample_real_start(sample_real_start), .dso_setZero(dso_setZero), .busy(busy),
      .run_end(run_end), .run_status(run_status)
   );

   always #5 core_clk = ~core_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge core_clk);
      @(negedge core_clk);
   endtask

   task automatic start_run(input logic [31:0] d, input logic [31:0] p, input logic te, input logic zr, input logic fs);
      cfg_depth = d; cfg_trig_pos = p; cfg_trig_en = te; cfg_zero_req = zr; cfg_full_speed = fs;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
   endtask

   initial begin
      int cyc, pulses;
      bit seen, fell;
      repeat (2) tick();
      core_rst = 1'b0;
      chk("rst_sample_en", 32'(sample_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_status", 32'(run_status), 0);
      chk("rst_depth", sample_depth, 0);
      // normal triggered run: sample_en rises 5 cycles after start
      start_run(1024, 256, 1'b1, 1'b0, 1'b0);
      chk("t1_busy", 32'(busy), 1);
      repeat (3) tick();
      chk("t1_en_low_c4", 32'(sample_en), 0);
      tick();
      chk("t1_en_high_c5", 32'(sample_en), 1);
      chk("t1_depth", sample_depth, 1024);
      chk("t1_last", sample_last_cnt, 1023);
      chk("t1_pos", trig_set_pos, 256);
      chk("t1_pos_m1", trig_set_pos_minus1, 255);
      chk("t1_after", after_trig_depth, 767);
      chk("t1_real_start", sample_real_start, 768);
      chk("t1_trig_en", 32'(trig_en), 1);
      cfg_depth = 50;
      run_start = 1'b1;
      tick();
      run_start = 1'b0;
      chk("busy_start_ignored", sample_depth, 1024);
      chk("busy_start_en", 32'(sample_en), 1);
      // capture_done then slow writer drain
      wr_idle = 1'b0;
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      chk("t2_en_fall", 32'(sample_en), 0);
      repeat (10) tick();
      chk("t2_no_end_flush", 32'(run_end), 0);
      chk("t2_busy_flush", 32'(busy), 1);
      wr_idle = 1'b1;
      tick();
      chk("t2_run_end", 32'(run_end), 1);
      chk("t2_status", 32'(run_status), 0);
      tick();
      chk("t2_end_pulse", 32'(run_end), 0);
      chk("t2_idle", 32'(busy), 0);
      // depth below minimum
      start_run(8, 2, 1'b1, 1'b0, 1'b0);
      chk("t3_en_c1", 32'(sample_en), 0);
      tick();
      chk("t3_run_end", 32'(run_end), 1);
      chk("t3_status", 32'(run_status), 2);
      chk("t3_en_c2", 32'(sample_en), 0);
      tick();
      chk("t3_idle", 32'(busy), 0);
      // non-trigger run, then run_stop while settling
      start_run(1024, 256, 1'b0, 1'b0, 1'b1);
      tick();
      chk("nt_pos", trig_set_pos, 0);
      chk("nt_pos_m1", trig_set_pos_minus1, 0);
      chk("nt_real_start", sample_real_start, 0);
      chk("nt_after", after_trig_depth, 1023);
      chk("nt_full_speed", 32'(full_speed), 1);
      run_stop = 1'b1;
      tick();
      run_stop = 1'b0;
      chk("settle_stop_en", 32'(sample_en), 0);
      tick();
      chk("settle_stop_end", 32'(run_end), 1);
      chk("settle_stop_status", 32'(run_status), 1);
      tick();
      // zero calibration timeout with writer held busy
      wr_idle = 1'b0;
      start_run(1024, 10, 1'b1, 1'b1, 1'b0);
      cyc = 1; pulses = 0; seen = 0; fell = 0;
      for (int i = 0; i < 200 && !fell; i++) begin
         tick();
         cyc++;
         if (dso_setZero) pulses++;
         if (sample_en) seen = 1;
         else if (seen) fell = 1;
      end
      chk("t4_fall_cycle", 32'(cyc), 69);
      chk("t4_pulses", 32'(pulses), 1);
      chk("t4_flush_busy", 32'(busy), 1);
      chk("t4_flush_no_end", 32'(run_end), 0);
      wr_idle = 1'b1;
      tick();
      chk("t4_run_end", 32'(run_end), 1);
      chk("t4_status", 32'(run_status), 3);
      tick();
      // zero calibration completes, then capture_done and run_stop together
      start_run(1024, 256, 1'b1, 1'b1, 1'b0);
      repeat (4) tick();
      chk("z_en_c5", 32'(sample_en), 1);
      chk("z_pulse_c5", 32'(dso_setZero), 1);
      tick();
      chk("z_pulse_c6", 32'(dso_setZero), 0);
      dso_setZero_done = 1'b1;
      tick();
      dso_setZero_done = 1'b0;
      chk("z_done_en_low", 32'(sample_en), 0);
      repeat (3) tick();
      chk("z_resettle_low", 32'(sample_en), 0);
      tick();
      chk("z_arm_en", 32'(sample_en), 1);
      run_stop = 1'b1; capture_done = 1'b1;
      tick();
      run_stop = 1'b0; capture_done = 1'b0;
      chk("t5a_en_fall", 32'(sample_en), 0);
      tick();
      chk("t5a_run_end", 32'(run_end), 1);
      chk("t5a_status", 32'(run_status), 0);
      tick();
      // run_stop alone in ARM
      start_run(1024, 256, 1'b1, 1'b0, 1'b0);
      repeat (4) tick();
      chk("t5b_arm", 32'(sample_en), 1);
      run_stop = 1'b1;
      tick();
      run_stop = 1'b0;
      tick();
      chk("t5b_run_end", 32'(run_end), 1);
      chk("t5b_status", 32'(run_status), 1);
      tick();
      // clamped position, then reset mid-run
      start_run(100, 500, 1'b1, 1'b0, 1'b0);
      tick();
      chk("t6_pos", trig_set_pos, 99);
      chk("t6_after", after_trig_depth, 0);
      chk("t6_real_start", sample_real_start, 1);
      repeat (3) tick();
      chk("t6_arm", 32'(sample_en), 1);
      core_rst = 1'b1;
      tick();
      core_rst = 1'b0;
      chk("t6_rst_en", 32'(sample_en), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_no_end", 32'(run_end), 0);
      chk("t6_rst_status", 32'(run_status), 0);
      tick();
      chk("t6_rst_no_end_later", 32'(run_end), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
